uart_tx_scheduler: RTL
======================

# uart_tx_scheduler

Round-robin scheduler that shares one `UART_Tx` transmitter among `N_REQ` byte requesters. It grants one requester at a time and drives the transmitter's `data` / `byte_ready` / `t_byte` load-and-start sequence. `UART_Tx` has no busy output, so the scheduler times each frame with its own counter. It sits directly in front of `UART_Tx`, and the transmitter's `Tx` output passes through untouched.

## Interface
- `N_REQ`, default 4: number of requesters, 2..16.
- `CLKS_PER_BIT`, default 5208: clocks per serial bit. Must match the `UART_Tx` build.
- `FRAME_BITS`, default 10: bits per frame (start + 8 data + stop).
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  when low, no new grant is issued; an in-flight frame still completes.
- `req`  in  N_REQ  per-requester byte request, level.
- `req_data`  in  N_REQ×8  packed bytes; requester i uses bits [8i+7:8i].
- `ack`  out  N_REQ  one-cycle pulse, one-hot: the byte of that requester has been captured.
- `busy`  out  1  high in every state except IDLE.
- `grant_id`  out  $clog2(N_REQ)  index of the current/last granted requester.
- `tx_data`  out  8  to `UART_Tx.data`, registered.
- `byte_ready`  out  1  to `UART_Tx.byte_ready`.
- `t_byte`  out  1  to `UART_Tx.t_byte`.

## Operation
- States: IDLE, LOAD, START, WAIT.
- **IDLE**
  - If `enable` is high and any `req` bit is high: pick the winner round-robin, starting the search at `last_grant+1` mod N_REQ.
  - On that clock edge, register `req_data[winner]` into `tx_data`, `winner` into `grant_id` and `last_grant`, then go to LOAD.
  - Otherwise stay in IDLE.
- **LOAD** (1 cycle): `byte_ready`=1, `ack[grant_id]`=1. Go to START.
- **START** (1 cycle): `byte_ready`=1, `t_byte`=1. Clear the frame counter. Go to WAIT.
- **WAIT**:
  - `byte_ready`=0, `t_byte`=0.
  - The counter increments each cycle.
  - Leave to IDLE on the cycle where counter = FRAME_BITS×CLKS_PER_BIT−1, so WAIT lasts exactly FRAME_BITS×CLKS_PER_BIT cycles.
- Requester handshake:
  - Hold `req` and the byte stable until `ack` is seen.
  - The byte is already latched when `ack` rises.
  - A `req` still high when the scheduler next reaches IDLE counts as a new request, including for the same requester.
- `tx_data` holds its value from the IDLE→LOAD edge until the next grant.
- Counter width: $clog2(FRAME_BITS×CLKS_PER_BIT). Unsigned compare; no wrap-around inside a frame.

## Timing
- Reset (asynchronous, `reset`=0):
  - state IDLE.
  - `ack`, `busy`, `byte_ready`, `t_byte`, `tx_data`, `grant_id` = 0.
  - `last_grant` = N_REQ−1, so requester 0 has first priority.
  - Frame counter = 0.
- Grant latency: a request seen in IDLE at cycle t gives `ack` and `byte_ready` at t+1, `t_byte` at t+2, and WAIT from t+3 to t+2+FRAME_BITS×CLKS_PER_BIT. IDLE is reachable again at t+3+FRAME_BITS×CLKS_PER_BIT.
- Back-to-back frame period: FRAME_BITS×CLKS_PER_BIT+3 cycles.
- Simultaneous requests: exactly one `ack` per frame. The others wait. No requester waits more than N_REQ−1 frames.
- `enable` falling during LOAD, START or WAIT: the current frame completes and no new grant follows. `enable` rising in IDLE: a grant may occur on that same cycle.
- `req` dropping after the IDLE→LOAD edge: no effect on the frame already captured.
- Reset asserted mid-frame: immediate return to the reset values. The frame is abandoned, and no `ack` follows if the reset lands before LOAD.
- All outputs are registered. No combinational path from `req` to any output.

## Structure
- Shared package `uart_pkg`:
  - `sched_state_t` enum (IDLE, LOAD, START, WAIT).
  - `FRAME_BITS_DEFAULT` = 10.
  - `CLKS_PER_BIT_DEFAULT` = 5208.
- Sub-module `rr_arbiter`:
  - Combinational round-robin pick.
  - Inputs: `req` vector, `last_grant`.
  - Outputs: `winner` index, `any_req`.
  - Parameterised by N_REQ.
- The scheduler holds the FSM, frame counter, data register and ack generation. `UART_Tx` is instantiated one level up, not inside.

## Test plan
Bench settings: N_REQ=4, CLKS_PER_BIT=4, FRAME_BITS=10 (WAIT = 40 cycles).
- **Single request**: `req`=4'b0010 with byte 8'h45 → `ack`=4'b0010 and `byte_ready`=1 one cycle later, `t_byte` pulse the next cycle, `tx_data`=8'h45. `busy` is high for 42 cycles. `Tx` from the attached `UART_Tx` shows 0,1,0,1,0,0,0,1,0,1.
- **All four requesting continuously** → `ack` order 0,1,2,3,0, spaced 43 cycles apart.
- **Fairness after reset**: requesters 3 and 0 both request → 0 is granted first, then 3.
- **`enable` dropped during WAIT** with `req`=4'b1111 → the frame finishes at its normal cycle, `busy` falls, and no `ack` occurs until `enable` returns. The grant then occurs on the cycle `enable` returns.
- **Reset pulsed at WAIT counter=20** → all outputs 0 immediately. After release, a held `req` is re-granted starting from requester 0.
- **Requester drops `req` the cycle after `ack`**, byte 8'hA5 → the frame still completes with `tx_data`=8'hA5. A following IDLE with `req`=0 stays idle with `busy`=0.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit scheduler:
//   sched_state_t        - scheduler FSM states
//   FRAME_BITS_DEFAULT   - start + 8 data + stop
//   CLKS_PER_BIT_DEFAULT - clocks per serial bit for the reference UART_Tx build
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        START = 2'd2,
        WAIT  = 2'd3
    } sched_state_t;

    localparam int FRAME_BITS_DEFAULT   = 10;
    localparam int CLKS_PER_BIT_DEFAULT = 5208;

    // Index width for a requester count; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// -----------------------------------------------------------------------------
// uart_tx_scheduler_if
// Requester / transmitter bundle around the scheduler.
//   enable, req, req_data           : requester side -> scheduler
//   ack, busy, grant_id             : scheduler -> requester side
//   tx_data, byte_ready, t_byte     : scheduler -> UART_Tx load/start pins
// Modports: master = requester/system side, slave = scheduler.
// -----------------------------------------------------------------------------
interface uart_tx_scheduler_if
    import uart_pkg::*;
#(
    parameter int N_REQ = 4
);
    localparam int GID_W = idx_width(N_REQ);

    logic                 enable;
    logic [N_REQ-1:0]     req;
    logic [N_REQ*8-1:0]   req_data;
    logic [N_REQ-1:0]     ack;
    logic                 busy;
    logic [GID_W-1:0]     grant_id;
    logic [7:0]           tx_data;
    logic                 byte_ready;
    logic                 t_byte;

    modport master (
        output enable, req, req_data,
        input  ack, busy, grant_id, tx_data, byte_ready, t_byte
    );

    modport slave (
        input  enable, req, req_data,
        output ack, busy, grant_id, tx_data, byte_ready, t_byte
    );
endinterface

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick. The search starts one past the last grant
// and wraps modulo N_REQ, so the previous winner has lowest priority.
//   i_req        : request vector
//   i_last_grant : index granted last time
//   o_winner     : chosen index (holds i_last_grant when nothing requests)
//   o_any_req    : at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter
    import uart_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int GID_W = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [GID_W-1:0] i_last_grant,
    output logic [GID_W-1:0] o_winner,
    output logic             o_any_req
);

    // Scan from the farthest offset down to the nearest so the nearest
    // requesting index after the last grant is the final assignment.
    always_comb begin
        int w_idx;
        w_idx     = 0;
        o_winner  = i_last_grant;
        o_any_req = |i_req;
        for (int off = N_REQ; off >= 1; off--) begin
            w_idx = (int'(i_last_grant) + off) % N_REQ;
            if (i_req[GID_W'(w_idx)]) begin
                o_winner = GID_W'(w_idx);
            end else begin
                o_winner = o_winner;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// uart_tx_scheduler
// Shares one UART_Tx among N_REQ byte requesters. Grants round-robin, latches
// the winner's byte, drives the UART_Tx load (byte_ready) and start (t_byte)
// sequence, then times the frame with its own counter since UART_Tx has no
// busy output.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : uart_tx_scheduler_if.slave (requests, acks, UART_Tx load pins)
// All outputs are registered.
// -----------------------------------------------------------------------------
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int FRAME_BITS   = FRAME_BITS_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    uart_tx_scheduler_if.slave     bus
);

    localparam int GID_W      = idx_width(N_REQ);
    localparam int FRAME_CLKS = FRAME_BITS * CLKS_PER_BIT;
    localparam int CNT_W      = idx_width(FRAME_CLKS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CLKS - 1);

    sched_state_t       r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [N_REQ-1:0]   r_ack;
    logic               r_busy;
    logic [GID_W-1:0]   r_grant_id;
    logic [GID_W-1:0]   r_last_grant;
    logic [7:0]         r_tx_data;
    logic               r_byte_ready;
    logic               r_t_byte;

    logic [GID_W-1:0]   w_winner;
    logic               w_any_req;
    logic [7:0]         w_sel_byte;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .i_req        (bus.req),
        .i_last_grant (r_last_grant),
        .o_winner     (w_winner),
        .o_any_req    (w_any_req)
    );

    // Byte of the current arbitration winner.
    always_comb begin
        w_sel_byte = bus.req_data[int'(w_winner)*8 +: 8];
    end

    // Scheduler FSM; every output is set on the edge entering its state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_ack        <= '0;
            r_busy       <= 1'b0;
            r_grant_id   <= '0;
            r_last_grant <= GID_W'(N_REQ - 1);
            r_tx_data    <= 8'h00;
            r_byte_ready <= 1'b0;
            r_t_byte     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.enable && w_any_req) begin
                        r_state      <= LOAD;
                        r_tx_data    <= w_sel_byte;
                        r_grant_id   <= w_winner;
                        r_last_grant <= w_winner;
                        r_ack        <= N_REQ'(1) << w_winner;
                        r_byte_ready <= 1'b1;
                        r_busy       <= 1'b1;
                    end else begin
                        r_state      <= IDLE;
                    end
                end
                LOAD: begin
                    r_state      <= START;
                    r_ack        <= '0;
                    r_byte_ready <= 1'b1;
                    r_t_byte     <= 1'b1;
                end
                START: begin
                    r_state      <= WAIT;
                    r_byte_ready <= 1'b0;
                    r_t_byte     <= 1'b0;
                    r_cnt        <= '0;
                end
                WAIT: begin
                    // Leaving on CNT_LAST makes WAIT exactly FRAME_CLKS cycles.
                    if (r_cnt == CNT_LAST) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_cnt        <= '0;
                    r_ack        <= '0;
                    r_busy       <= 1'b0;
                    r_byte_ready <= 1'b0;
                    r_t_byte     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ack        = r_ack;
    assign bus.busy       = r_busy;
    assign bus.grant_id   = r_grant_id;
    assign bus.tx_data    = r_tx_data;
    assign bus.byte_ready = r_byte_ready;
    assign bus.t_byte     = r_t_byte;

endmodule
